// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: the FSM state
// encoding and the parity-type constants.
// Build option: UART_TX_TWO_STOP_EN selects two stop bits per frame.
package uart_tx_pkg;

  // STOP2 keeps its encoding in every build; it is only reachable
  // when two stop bits are compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity generator: XOR-reduces the parallel word, applies the parity
// type, and holds the result from the accept edge until the next accept.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  SER_CLK,
  input  logic                  SER_RST,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  logic par_bit_d;
  logic par_bit_q;

  // Even parity is the plain XOR of the word; odd parity is its inverse.
  always_comb begin
    par_bit_d = ^data_i;
    if (par_typ_i == PAR_ODD) par_bit_d = ~par_bit_d;
  end

  // Capture the parity bit only when a word is accepted.
  // NOTE: async active-low reset in the sensitivity list, and <= for every
  // sequential assignment so all flops update together at the edge.
  always_ff @(posedge SER_CLK or negedge SER_RST) begin
    if (!SER_RST)    par_bit_q <= 1'b0;
    else if (load_i) par_bit_q <= par_bit_d;
  end

  assign par_bit_o = par_bit_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a parallel word, sequences the
// external serializer through ser_en and muxes start, data, optional
// parity and stop bits onto TX_OUT (idle high, one SER_CLK per bit).
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  SER_CLK,
  input  logic                  SER_RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q;
  logic      par_en_q;
  logic      par_bit;
  logic      accept;

  // A request is honoured only while idle; anything else is dropped.
  assign accept = (state_q == IDLE) && DATA_VALID;

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .SER_CLK   (SER_CLK),
    .SER_RST   (SER_RST),
    .load_i    (accept),
    .data_i    (P_DATA),
    .par_typ_i (PAR_TYP),
    .par_bit_o (par_bit)
  );

  // Frame sequencer; PAR_EN is latched at accept so mid-frame changes
  // cannot alter the frame already in flight.
  always_ff @(posedge SER_CLK or negedge SER_RST) begin
    if (!SER_RST) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (DATA_VALID) begin
            par_en_q <= PAR_EN;
            state_q  <= START;
          end
        end
        START:  state_q <= DATA;
        DATA: begin
          if (ser_done) state_q <= par_en_q ? PARITY : STOP;
        end
        PARITY: state_q <= STOP;
`ifdef UART_TX_TWO_STOP_EN
        STOP:   state_q <= STOP2;
        STOP2:  state_q <= IDLE;
`else
        STOP:   state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line and handshake decode from the state register; ser_en follows
  // ser_done combinationally so the serializer stops on its last bit.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    Busy   = (state_q != IDLE);
    case (state_q)
      START: begin
        TX_OUT = 1'b0;
        ser_en = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = ~ser_done;
      end
      PARITY:  TX_OUT = par_bit;
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule
